// File: rtl/uart_msg_assembler.sv
// Frames DATA_WIDTH UART words (LSB word first) into a MSG_WIDTH message split into header/payload.
// Optional inter-word timeout resynchronisation is built when UART_MSG_TIMEOUT_EN is defined.
module uart_msg_assembler #(
  parameter int DATA_WIDTH   = 8,
  parameter int MSG_WIDTH    = 64,
  parameter int HEADER_WIDTH = 8,
  parameter int TIMEOUT_CLKS = 200_000,
  localparam int WORDS       = MSG_WIDTH / DATA_WIDTH,
  localparam int CW          = $clog2(WORDS) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [HEADER_WIDTH-1:0]       out_header,
  output logic [MSG_WIDTH-HEADER_WIDTH-1:0] out_payload,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CW-1:0]                 word_count,
  output logic                          overrun_err,
  output logic                          timeout_err
);

  generate
    if (MSG_WIDTH % DATA_WIDTH != 0) begin : g_bad_msg_width
      $error("MSG_WIDTH must be a multiple of DATA_WIDTH");
    end
    if (HEADER_WIDTH <= 0 || HEADER_WIDTH >= MSG_WIDTH) begin : g_bad_header_width
      $error("HEADER_WIDTH must satisfy 0 < HEADER_WIDTH < MSG_WIDTH");
    end
    if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
      $error("TIMEOUT_CLKS must be at least 1");
    end
  endgenerate

  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WORDS);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t               state;
  logic [MSG_WIDTH-1:0] msg;
  logic                 expire;

  assign in_ready    = (state == COLLECT) | out_ready;
  assign out_header  = msg[HEADER_WIDTH-1:0];
  assign out_payload = msg[MSG_WIDTH-1:HEADER_WIDTH];

`ifdef UART_MSG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] timer;
  logic          timer_run;

  // Only a partially collected message can go stale; idle or held states never time out.
  assign timer_run = (state == COLLECT) && (word_count != '0);
  assign expire    = timer_run && (timer == TW'(TIMEOUT_CLKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire;
      if (!timer_run || in_valid || expire)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      msg         <= '0;
      word_count  <= '0;
      out_valid   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= in_valid & ~in_ready;
      case (state)
        COLLECT: begin
          // On expiry the stale partial message is dropped; a coincident word restarts framing.
          if (expire) begin
            word_count <= in_valid ? CW'(1) : '0;
            if (in_valid)
              msg[DATA_WIDTH-1:0] <= in_data;
          end else if (in_valid) begin
            for (int k = 0; k < WORDS; k++)
              if (word_count == CW'(k))
                msg[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            if (word_count == LAST_IDX) begin
              state      <= HOLD;
              out_valid  <= 1'b1;
              word_count <= FULL_CNT;
            end else begin
              word_count <= word_count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (in_valid) begin
              msg[DATA_WIDTH-1:0] <= in_data;
              if (WORDS == 1) begin
                out_valid  <= 1'b1;
                word_count <= FULL_CNT;
              end else begin
                state      <= COLLECT;
                out_valid  <= 1'b0;
                word_count <= CW'(1);
              end
            end else begin
              state      <= COLLECT;
              out_valid  <= 1'b0;
              word_count <= '0;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Scoreboard bench for uart_msg_assembler: default 64-bit framing plus a 32-bit/4-bit-header instance.
module tb_uart_msg_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_header;
  logic [55:0] out_payload;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  word_count;
  logic        overrun_err;
  logic        timeout_err;

  logic [7:0]  in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic [3:0]  out_header2;
  logic [27:0] out_payload2;
  logic        out_valid2;
  logic        out_ready2;
  logic [2:0]  word_count2;
  logic        overrun_err2;
  logic        timeout_err2;

  int assertCount  = 0;
  int failCount    = 0;
  int overrunCount = 0;
  int timeoutCount = 0;
  logic [63:0] expQ[$];

  uart_msg_assembler #(.DATA_WIDTH(8), .MSG_WIDTH(64), .HEADER_WIDTH(8), .TIMEOUT_CLKS(16)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_header(out_header), .out_payload(out_payload), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count), .overrun_err(overrun_err),
    .timeout_err(timeout_err));

  uart_msg_assembler #(.DATA_WIDTH(8), .MSG_WIDTH(32), .HEADER_WIDTH(4), .TIMEOUT_CLKS(16)) u_dut32 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_header(out_header2), .out_payload(out_payload2), .out_valid(out_valid2),
    .out_ready(out_ready2), .word_count(word_count2), .overrun_err(overrun_err2),
    .timeout_err(timeout_err2));

  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sendRange(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(first + 8'(i));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 50 && expQ.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
  endtask

  // Scoreboard consumer: a message leaves on every valid/ready handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected message", {out_payload, out_header}, 64'd0);
      end else begin
        logic [63:0] e;
        e = expQ.pop_front();
        checkOutput("message header", 64'(out_header), 64'(e[7:0]));
        checkOutput("message payload", 64'(out_payload), 64'(e[63:8]));
      end
    end
    if (!rst && overrun_err) overrunCount++;
    if (!rst && timeout_err) timeoutCount++;
  end

  initial begin
    int ovBefore;
    int toBefore;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    idleCycles(3);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset word_count", 64'(word_count), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset overrun_err", 64'(overrun_err), 64'd0);
    checkOutput("reset timeout_err", 64'(timeout_err), 64'd0);
    rst = 1'b0;
    idleCycles(1);

    // Basic message with the consumer always ready.
    expQ.push_back(64'h0807060504030201);
    sendRange(8'h01, 8);
    checkOutput("full out_valid", 64'(out_valid), 64'd1);
    checkOutput("full word_count", 64'(word_count), 64'd8);
    idleCycles(1);
    checkOutput("after handshake out_valid", 64'(out_valid), 64'd0);
    checkOutput("after handshake word_count", 64'(word_count), 64'd0);
    waitDrain();

    // Back-pressure with a dropped word.
    out_ready = 1'b0;
    expQ.push_back(64'h0807060504030201);
    sendRange(8'h01, 8);
    checkOutput("hold in_ready", 64'(in_ready), 64'd0);
    applyStimulus(8'hAA);
    checkOutput("overrun pulse", 64'(overrun_err), 64'd1);
    checkOutput("held header", 64'(out_header), 64'h01);
    checkOutput("held payload", 64'(out_payload), 64'h08070605040302);
    checkOutput("held word_count", 64'(word_count), 64'd8);
    idleCycles(1);
    checkOutput("overrun one cycle", 64'(overrun_err), 64'd0);
    out_ready = 1'b1;
    idleCycles(1);
    checkOutput("released out_valid", 64'(out_valid), 64'd0);
    waitDrain();

    // Handshake and first word of the next message in the same cycle.
    out_ready = 1'b0;
    expQ.push_back(64'h1817161514131211);
    sendRange(8'h11, 8);
    expQ.push_back(64'h6C6B6A6968676655);
    out_ready = 1'b1;
    applyStimulus(8'h55);
    checkOutput("overlap word_count", 64'(word_count), 64'd1);
    checkOutput("overlap out_valid", 64'(out_valid), 64'd0);
    sendRange(8'h66, 7);
    checkOutput("overlap next out_valid", 64'(out_valid), 64'd1);
    waitDrain();

`ifdef UART_MSG_TIMEOUT_EN
    begin
      int waited;
      bit seen;
      waited = 0;
      seen = 1'b0;
      sendRange(8'h21, 3);
      for (int i = 0; i < 24 && !seen; i++) begin
        @(posedge clk); #1;
        waited++;
        if (timeout_err) seen = 1'b1;
      end
      checkOutput("timeout pulse", 64'(seen), 64'd1);
      checkOutput("timeout not early", 64'(waited >= 16), 64'd1);
      checkOutput("timeout word_count", 64'(word_count), 64'd0);
      idleCycles(1);
      checkOutput("timeout one cycle", 64'(timeout_err), 64'd0);
      expQ.push_back(64'h3837363534333231);
      sendRange(8'h31, 8);
      waitDrain();
    end
`else
    checkOutput("timeout tied low", 64'(timeout_err), 64'd0);
`endif

    // Narrow message on the 32-bit instance.
    begin
      logic [7:0] bytes [4];
      bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int i = 0; i < 4; i++) begin
        in_valid2 = 1'b1;
        in_data2  = bytes[i];
        @(posedge clk); #1;
      end
      in_valid2 = 1'b0;
      checkOutput("n32 out_valid", 64'(out_valid2), 64'd1);
      checkOutput("n32 header", 64'(out_header2), 64'hE);
      checkOutput("n32 payload", 64'(out_payload2), 64'hEFBEADD);
      checkOutput("n32 word_count", 64'(word_count2), 64'd4);
      idleCycles(1);
      checkOutput("n32 released", 64'(out_valid2), 64'd0);
    end

    // Reset in the middle of a message discards it silently.
    ovBefore = overrunCount;
    toBefore = timeoutCount;
    sendRange(8'h41, 5);
    rst = 1'b1;
    idleCycles(2);
    checkOutput("midreset word_count", 64'(word_count), 64'd0);
    checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    idleCycles(1);
    expQ.push_back(64'h5857565554535251);
    sendRange(8'h51, 8);
    waitDrain();
    checkOutput("midreset no overrun", 64'(overrunCount - ovBefore), 64'd0);
    checkOutput("midreset no timeout", 64'(timeoutCount - toBefore), 64'd0);
    checkOutput("total overrun pulses", 64'(overrunCount), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
